// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32 instruction encoder.
// Request side carries unpacked fields; response side carries the packed word.
interface instr_encoder_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [REG_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic [WIDTH-1:0]     imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_inst;
    logic [WIDTH-1:0]     out_addr;
    logic [1:0]           out_err;

    // Producer of instruction fields and consumer of encoded words.
    modport master (
        output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    // Encoder side.
    modport slave (
        input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage pipelined RV32 instruction encoder (inverse of the decoder).
// S1 registers the fields and their format class; S2 packs the word and
// flags errors; out_addr counts bytes of delivered words.
// Optional macro INSTR_ENCODER_IMM_CHECK_EN enables immediate range checking;
// without it out_err[0] stays 0 and immediates are truncated to the packed bits.
module instr_encoder #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     REG_WIDTH = 5,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    instr_encoder_if.slave   bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
    } fmt_e;

    fmt_e                 w_fmt;
    logic                 w_s2_ready;
    logic                 w_in_ready;
    logic                 w_is_shift;
    logic                 w_imm_bad;
    logic [31:0]          w_inst;
    logic [1:0]           w_err;

    logic                 r_s1_valid;
    fmt_e                 r_s1_fmt;
    logic [6:0]           r_s1_op;
    logic [2:0]           r_s1_f3;
    logic [6:0]           r_s1_f7;
    logic [REG_WIDTH-1:0] r_s1_rd;
    logic [REG_WIDTH-1:0] r_s1_rs1;
    logic [REG_WIDTH-1:0] r_s1_rs2;
    logic [WIDTH-1:0]     r_s1_imm;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_inst;
    logic [WIDTH-1:0]     r_out_addr;
    logic [1:0]           r_out_err;

    assign w_s2_ready    = !r_out_valid || bus.out_ready;
    assign w_in_ready    = !clear && (!r_s1_valid || w_s2_ready);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_err   = r_out_err;

    // Shift-immediates carry funct7 in the upper immediate bits.
    assign w_is_shift = (r_s1_op == 7'b0010011) &&
                        ((r_s1_f3 == 3'b001) || (r_s1_f3 == 3'b101));

    // Format class from the major opcode bits.
    always_comb begin
        w_fmt = FMT_X;
        case (bus.opcode[6:2])
            5'b01101, 5'b00101:                            w_fmt = FMT_U;
            5'b00001, 5'b11001, 5'b00000, 5'b00100, 5'b00110: w_fmt = FMT_I;
            5'b01011, 5'b01100, 5'b01110, 5'b10100:        w_fmt = FMT_R;
            5'b01001, 5'b01000:                            w_fmt = FMT_S;
            5'b11000:                                      w_fmt = FMT_B;
            5'b11011:                                      w_fmt = FMT_J;
            default:                                       w_fmt = FMT_X;
        endcase
    end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    // Immediate must be representable by the format's sign-extended field.
    always_comb begin
        w_imm_bad = 1'b0;
        case (r_s1_fmt)
            FMT_I: w_imm_bad = w_is_shift ? (|r_s1_imm[31:5])
                             : !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
            FMT_S: w_imm_bad = !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
            FMT_B: w_imm_bad = r_s1_imm[0] ||
                               !((&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]));
            FMT_J: w_imm_bad = r_s1_imm[0] ||
                               !((&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]));
            FMT_U: w_imm_bad = |r_s1_imm[11:0];
            default: w_imm_bad = 1'b0;
        endcase
    end
`else
    assign w_imm_bad = 1'b0;
`endif

    // Pack S1 fields into the instruction word; errors substitute a NOP.
    always_comb begin
        w_inst = NOP;
        w_err  = 2'b00;
        case (r_s1_fmt)
            FMT_R: w_inst = 32'({r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op});
            FMT_I: begin
                if (w_is_shift)
                    w_inst = 32'({r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op});
                else
                    w_inst = 32'({r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op});
            end
            FMT_S: w_inst = 32'({r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                                 r_s1_imm[4:0], r_s1_op});
            FMT_B: w_inst = 32'({r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                                 r_s1_f3, r_s1_imm[4:1], r_s1_imm[11], r_s1_op});
            FMT_U: w_inst = 32'({r_s1_imm[31:12], r_s1_rd, r_s1_op});
            FMT_J: w_inst = 32'({r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                                 r_s1_imm[19:12], r_s1_rd, r_s1_op});
            default: w_err[1] = 1'b1;
        endcase
        if (r_s1_fmt != FMT_X) w_err[0] = w_imm_bad;
        if (w_err != 2'b00) w_inst = NOP;
    end

    // Pipeline registers, output register and address counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= FMT_X;
            r_s1_op     <= '0;
            r_s1_f3     <= '0;
            r_s1_f7     <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_imm    <= '0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_err   <= '0;
            r_out_addr  <= BASE_ADDR;
        end else if (clear) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= BASE_ADDR;
        end else begin
            if (r_out_valid && bus.out_ready)
                r_out_addr <= r_out_addr + WIDTH'(4);
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_inst <= WIDTH'(w_inst);
                    r_out_err  <= w_err;
                end
            end
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_fmt <= w_fmt;
                    r_s1_op  <= bus.opcode;
                    r_s1_f3  <= bus.funct3;
                    r_s1_f7  <= bus.funct7;
                    r_s1_rd  <= bus.rd;
                    r_s1_rs1 <= bus.rs1;
                    r_s1_rs2 <= bus.rs2;
                    r_s1_imm <= bus.imm;
                end
            end
        end
    end
endmodule
